// File: rtl/seg_scan_if.sv
// Host-side control bus and display outputs of the multiplexed 7-segment scanner.
interface seg_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] digit_data;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    load;
  logic [3:0]              brightness;
  logic [6:0]              seg_cathode;
  logic                    seg_dp;
  logic [NUM_DIGITS-1:0]   seg_anode;
  logic                    frame_tick;
  logic                    pending;

  modport master (
    output digit_data, dp_in, blank_mask, blink_mask, load, brightness,
    input  seg_cathode, seg_dp, seg_anode, frame_tick, pending
  );
  modport slave (
    input  digit_data, dp_in, blank_mask, blink_mask, load, brightness,
    output seg_cathode, seg_dp, seg_anode, frame_tick, pending
  );
endinterface

// File: rtl/seg_scan_engine.sv
// Double-buffered multiplexed 7-segment scanner with PWM dimming.
// Define SEG_SCAN_BLINK_EN to build the per-digit blink feature.
module seg_scan_engine #(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 2000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink;
  } frame_buf_t;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  frame_buf_t            act_q, pend_q, in_w, src_w;
  logic [SW-1:0]         slot_q;
  logic [DW-1:0]         digit_q;
  logic [3:0]            pwm_q;
  logic                  ft_q, pending_q, last_w, lit_w, blink_dark_w;
  logic [NUM_DIGITS-1:0] onehot_w, anode_q;
  logic [6:0]            cath_q;
  logic                  dp_q;
  logic [3:0]            nib_w;

  assign last_w = (slot_q == SW'(SCAN_DIV-1)) && (digit_q == DW'(NUM_DIGITS-1));
  assign in_w   = '{data: bus.digit_data, dp: bus.dp_in, blank: bus.blank_mask, blink: bus.blink_mask};

  // ft_q marks the last displayed cycle of a frame; its closing edge commits,
  // and a load on that same cycle bypasses straight into the active buffer.
  always_comb begin
    src_w = act_q;
    if (ft_q) src_w = bus.load ? in_w : pend_q;
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES) + 1;
  logic [BW-1:0] bcnt_q;
  logic          bon_q, bflip_w, bon_w;
  assign bflip_w = ft_q && (bcnt_q == BW'(BLINK_FRAMES-1));
  assign bon_w   = bflip_w ? ~bon_q : bon_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q <= '0;
      bon_q  <= 1'b1;
    end else begin
      if (ft_q) bcnt_q <= bflip_w ? '0 : bcnt_q + 1'b1;
      bon_q <= bon_w;
    end
  end
  assign blink_dark_w = src_w.blink[digit_q] & ~bon_w;
`else
  logic unused_blink;
  assign unused_blink = ^src_w.blink;
  assign blink_dark_w = 1'b0;
`endif

  assign nib_w = src_w.data[digit_q*4 +: 4];
  assign lit_w = ~src_w.blank[digit_q] && (pwm_q <= bus.brightness) && ~blink_dark_w;

  always_comb begin
    onehot_w = '0;
    onehot_w[digit_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q    <= '0;
      digit_q   <= '0;
      pwm_q     <= '0;
      ft_q      <= 1'b0;
      pending_q <= 1'b0;
      act_q     <= '{data: '0, dp: '0, blank: '1, blink: '0};
      pend_q    <= '{data: '0, dp: '0, blank: '1, blink: '0};
      anode_q   <= '0;
      cath_q    <= '0;
      dp_q      <= 1'b0;
    end else begin
      slot_q <= (slot_q == SW'(SCAN_DIV-1)) ? '0 : slot_q + 1'b1;
      if (slot_q == SW'(SCAN_DIV-1))
        digit_q <= (digit_q == DW'(NUM_DIGITS-1)) ? '0 : digit_q + 1'b1;
      pwm_q <= pwm_q + 1'b1;
      ft_q  <= last_w;
      if (bus.load) pend_q <= in_w;
      act_q <= src_w;
      if (ft_q)          pending_q <= 1'b0;
      else if (bus.load) pending_q <= 1'b1;
      anode_q <= lit_w ? onehot_w : '0;
      cath_q  <= lit_w ? hex7(nib_w) : 7'h00;
      dp_q    <= lit_w & src_w.dp[digit_q];
    end
  end

  assign bus.seg_anode   = anode_q;
  assign bus.seg_cathode = cath_q;
  assign bus.seg_dp      = dp_q;
  assign bus.frame_tick  = ft_q;
  assign bus.pending     = pending_q;
endmodule

// File: tb/tb_seg_scan_engine.sv
// Directed bench for seg_scan_engine: 8 digits, 16 clk per slot, 2-frame blink.
module tb_seg_scan_engine;
  localparam int ND = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  seg_scan_if #(.NUM_DIGITS(ND)) bus();
  seg_scan_engine #(.NUM_DIGITS(ND), .SCAN_DIV(16), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] font(input int n);
    case (n)
      0: font = 7'h3F; 1: font = 7'h06; 2: font = 7'h5B; 3: font = 7'h4F;
      4: font = 7'h66; 5: font = 7'h6D; 6: font = 7'h7D; 7: font = 7'h07;
      default: font = 7'h00;
    endcase
  endfunction

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                         input logic [7:0] bk);
    bus.digit_data = d; bus.dp_in = dp; bus.blank_mask = bl; bus.blink_mask = bk;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Returns at the negedge where frame_tick is seen.
  task automatic wait_ft();
    logic found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (bus.frame_tick) found = 1'b1;
    end
    chk("ft_seen", {31'd0, found}, 32'd1);
  endtask

  initial begin
    int cnt, stray, first;
    logic lit;
    bus.digit_data = '0; bus.dp_in = '0; bus.blank_mask = '0; bus.blink_mask = '0;
    bus.load = 1'b0; bus.brightness = 4'd15;
    #1;
    chk("rst_anode", {24'd0, bus.seg_anode}, 32'd0);
    chk("rst_cath",  {25'd0, bus.seg_cathode}, 32'd0);
    chk("rst_dp",    {31'd0, bus.seg_dp}, 32'd0);
    chk("rst_ft",    {31'd0, bus.frame_tick}, 32'd0);
    chk("rst_pend",  {31'd0, bus.pending}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Blank after reset: dark until something is committed
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.seg_anode != 0 || bus.seg_cathode != 0) cnt++;
    end
    chk("dark_after_rst", cnt, 0);

    // Basic commit and walk
    do_load(32'h76543210, 8'h01, 8'h00, 8'h00);
    chk("pend_set", {31'd0, bus.pending}, 32'd1);
    wait_ft();
    chk("pend_in_ft", {31'd0, bus.pending}, 32'd1);
    for (int c = 0; c < 128; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("pend_clr", {31'd0, bus.pending}, 32'd0);
        chk("dp_d0", {31'd0, bus.seg_dp}, 32'd1);
      end
      if (c == 16) chk("dp_d1", {31'd0, bus.seg_dp}, 32'd0);
      if (c % 16 == 0) begin
        chk($sformatf("walk_an%0d", c/16), {24'd0, bus.seg_anode}, 32'd1 << (c/16));
        chk($sformatf("walk_ca%0d", c/16), {25'd0, bus.seg_cathode}, {25'd0, font(c/16)});
      end
      if (c == 9) chk("walk_mid", {24'd0, bus.seg_anode}, 32'h01);
      if (c == 126) chk("ft_low", {31'd0, bus.frame_tick}, 32'd0);
      if (c == 127) chk("ft_period", {31'd0, bus.frame_tick}, 32'd1);
    end

    // Two loads before commit: last wins
    repeat (3) @(negedge clk);
    do_load(32'hFEDCBA98, 8'h00, 8'h00, 8'h00);
    chk("pend_l1", {31'd0, bus.pending}, 32'd1);
    do_load(32'h89ABCDEF, 8'h00, 8'h00, 8'h00);
    chk("pend_l2", {31'd0, bus.pending}, 32'd1);
    wait_ft();
    chk("pend_l2_ft", {31'd0, bus.pending}, 32'd1);
    @(negedge clk);
    chk("pend_l2_clr", {31'd0, bus.pending}, 32'd0);
    chk("last_wins", {25'd0, bus.seg_cathode}, 32'h71);
    chk("last_wins_an", {24'd0, bus.seg_anode}, 32'h01);

    // Load on the frame_tick cycle bypasses to active
    wait_ft();
    chk("pend_pre_byp", {31'd0, bus.pending}, 32'd0);
    do_load(32'h0000000A, 8'h00, 8'h00, 8'h00);
    chk("bypass_ca", {25'd0, bus.seg_cathode}, 32'h77);
    chk("bypass_an", {24'd0, bus.seg_anode}, 32'h01);
    chk("bypass_pend", {31'd0, bus.pending}, 32'd0);
    repeat (3) @(negedge clk);
    chk("bypass_pend2", {31'd0, bus.pending}, 32'd0);

    // PWM duty
    for (int b = 0; b < 3; b++) begin
      bus.brightness = (b == 0) ? 4'd3 : (b == 1) ? 4'd0 : 4'd15;
      repeat (2) @(negedge clk);
      cnt = 0; stray = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        if (bus.seg_anode != 0) cnt++;
        else if (bus.seg_cathode != 0 || bus.seg_dp) stray++;
      end
      chk($sformatf("pwm_duty_b%0d", bus.brightness), cnt, (b == 0) ? 4 : (b == 1) ? 1 : 16);
      chk($sformatf("pwm_dark_b%0d", bus.brightness), stray, 0);
    end

    // Reset mid-slot of digit 5 with a load pending
    do_load(32'h76543210, 8'h00, 8'h00, 8'h00);
    wait_ft();
    repeat (86) @(negedge clk);
    chk("pre_rst_an", {24'd0, bus.seg_anode}, 32'h20);
    do_load(32'h11111111, 8'hFF, 8'h00, 8'h00);
    chk("pre_rst_pend", {31'd0, bus.pending}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_an", {24'd0, bus.seg_anode}, 32'd0);
    chk("mid_rst_ca", {25'd0, bus.seg_cathode}, 32'd0);
    chk("mid_rst_dp", {31'd0, bus.seg_dp}, 32'd0);
    chk("mid_rst_pend", {31'd0, bus.pending}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0; first = 0;
    for (int n = 1; n <= 200 && first == 0; n++) begin
      @(negedge clk);
      if (bus.seg_anode != 0 || bus.seg_cathode != 0) cnt++;
      if (bus.frame_tick) first = n;
    end
    chk("post_rst_dark", cnt, 0);
    chk("post_rst_ft_at", first, 128);
    chk("post_rst_pend", {31'd0, bus.pending}, 32'd0);

    // Blink on digit 0; this load commits at the 2nd tick since reset
    @(negedge clk);
    do_load(32'h76543210, 8'h00, 8'h00, 8'h01);
    for (int f = 2; f <= 7; f++) begin
      wait_ft();
      @(negedge clk);
`ifdef SEG_SCAN_BLINK_EN
      lit = ((f / 2) % 2) == 0;
`else
      lit = 1'b1;
`endif
      chk($sformatf("blink_an_f%0d", f), {24'd0, bus.seg_anode}, lit ? 32'h01 : 32'h00);
      chk($sformatf("blink_ca_f%0d", f), {25'd0, bus.seg_cathode}, lit ? 32'h3F : 32'h00);
      repeat (16) @(negedge clk);
      chk($sformatf("blink_d1_f%0d", f), {24'd0, bus.seg_anode}, 32'h02);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/seg_scan_engine.md
SEG_SCAN_ENGINE -- requirements
Module: seg_scan_engine

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed 7-segment digits (range 2..16).
REQ-002 Parameter SCAN_DIV, default 2000, clk cycles per digit slot (minimum 16).
REQ-003 Parameter BLINK_FRAMES, default 64, frames per blink half-period.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 digit_data  input  4*NUM_DIGITS  hex nibble per digit; digit i at bits [4i+3:4i].
REQ-007 dp_in  input  NUM_DIGITS  decimal-point request per digit.
REQ-008 blank_mask  input  NUM_DIGITS  1 = digit dark.
REQ-009 blink_mask  input  NUM_DIGITS  1 = digit blinks.
REQ-010 load  input  1  single-cycle strobe; captures digit_data, dp_in, blank_mask and blink_mask.
REQ-011 brightness  input  4  PWM duty level, 0 = dimmest, 15 = full.
REQ-012 seg_cathode  output  7  active-high segments; bit0 = a through bit6 = g.
REQ-013 seg_dp  output  1  active-high decimal point.
REQ-014 seg_anode  output  NUM_DIGITS  active-high, at most one bit set.
REQ-015 frame_tick  output  1  one-cycle pulse at end of each full scan.
REQ-016 pending  output  1  captured data is waiting for commit.

Function
REQ-017 Slot counter SHALL count 0..SCAN_DIV-1; digit index SHALL advance 0 -> NUM_DIGITS-1 at slot end, wrapping to 0.
REQ-018 frame_tick SHALL be high exactly on the last clk of digit NUM_DIGITS-1's slot.
REQ-019 Double buffer: load SHALL write the pending buffer and set pending; the active buffer SHALL copy the pending buffer on the frame_tick edge, and that edge SHALL clear pending.
REQ-020 Repeated load before commit: last load wins; pending stays 1.
REQ-021 load coincident with frame_tick: the load's data SHALL go directly to the active buffer; pending SHALL be 0 afterwards.
REQ-022 Committed content SHALL first appear on digit 0 in the cycle after frame_tick; the display SHALL never show a mixed frame.
REQ-023 Decode: standard hex font, e.g. 0=7'h3F, 1=7'h06, 8=7'h7F, A=7'h77, F=7'h71.
REQ-024 A 4-bit PWM counter SHALL free-run every clk; the anode SHALL be on only while pwm_cnt <= brightness (duty (brightness+1)/16).
REQ-025 Outputs SHALL be registered, one cycle after the internal index/PWM state; cathode, dp and anode SHALL change on the same edge.
REQ-026 The brightness input SHALL be sampled every clk and does not use the double buffer.
REQ-027 A digit that is blank, or PWM-off, or in the blink-off phase SHALL drive anode 0, cathode 0 and dp 0.
REQ-028 Blink phase SHALL toggle every BLINK_FRAMES frame_ticks; the phase SHALL start "on".

Reset
REQ-029 When rst is low, all outputs SHALL be 0, with no clock required.
REQ-030 Reset SHALL also clear the slot, digit, PWM and blink counters and the pending flag, set the blink phase to "on", and set the active and pending blank masks to all ones.
REQ-031 Reset in mid-frame SHALL discard any uncommitted load; scanning SHALL restart at digit 0, slot 0 after release.

Configuration
REQ-032 The macro SEG_SCAN_BLINK_EN SHALL control the blink feature.
REQ-033 With SEG_SCAN_BLINK_EN defined, the blink counter and blink phase SHALL exist and operate per REQ-028.
REQ-034 Without SEG_SCAN_BLINK_EN, the blink logic SHALL be absent and blink_mask SHALL be ignored (treated as all 0).

Verification
REQ-035 NUM_DIGITS=8, SCAN_DIV=16, brightness=15, load 32'h76543210 with blank_mask 0 -> after commit, anode walks 8'h01..8'h80 at 16 clk per digit; cathode shows 7'h3F on digit 0; frame_tick is high every 128 clk.
REQ-036 Load, then a second load before frame_tick -> only the second data is displayed; pending goes 1 -> 1 -> 0 at frame_tick.
REQ-037 load asserted on the frame_tick cycle -> new data is shown on digit 0 in the next cycle; pending stays 0.
REQ-038 brightness=3 -> anode is high for 4 of every 16 clk within a slot; brightness=0 -> 1 of 16.
REQ-039 With SEG_SCAN_BLINK_EN, BLINK_FRAMES=2, blink_mask=8'h01 -> digit 0 is dark during frames 2-3 and lit during frames 0-1 and 4-5; the other digits are unaffected. Without the macro, digit 0 is always lit.
REQ-040 rst pulsed low mid-slot of digit 5 with a load pending -> outputs are 0 immediately; after release, scan starts at digit 0 and the display is dark (all blank) until the next load and commit.
